// File: rtl/game_state_ctrl.sv
// game_state_ctrl: turn sequencer and scorekeeper for the two-player VGA dodge game.
// Synchronises the start switch, generates the game tick, tracks collision-free survival
// per turn, and produces registered state, scores, winner, respawn and tick outputs.
module game_state_ctrl #(
    parameter int TICK_BITS     = 22,
    parameter int SURVIVE_TICKS = 16,
    parameter int WIN_SCORE     = 10
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hit,
    output logic [1:0] state,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] winner,
    output logic       respawn,
    output logic       tick
);

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    localparam logic [7:0]           SURV_L    = 8'(SURVIVE_TICKS);
    localparam logic [3:0]           WIN_L     = 4'(WIN_SCORE);
    localparam logic [TICK_BITS-1:0] PRESC_MAX = {TICK_BITS{1'b1}};

    // Saturating score increment; a score never moves past the winning value.
    function automatic logic [3:0] score_inc(input logic [3:0] s);
        if (s >= WIN_L) begin
            score_inc = WIN_L;
        end else begin
            score_inc = s + 4'd1;
        end
    endfunction

    logic                 start_meta_q, start_sync_q, start_prev_q;
    logic                 sync_v1_q, sync_v2_q, start_armed_q;
    logic                 start_rise_q, start_fall_q;
    logic [TICK_BITS-1:0] presc_q;
    logic                 tick_q;

    state_t     state_q, state_d;
    logic [3:0] p1_q, p1_d, p2_q, p2_d;
    logic [1:0] winner_q, winner_d;
    logic [7:0] survive_q, survive_d;
    logic       hit_sticky_q, hit_sticky_d;
    logic       respawn_q, respawn_d;

    logic [7:0] survive_inc_s;
    logic [3:0] active_score_s, next_score_s;
    logic       collide_s;

    // Start switch synchroniser and edge detector. The edge detector only arms once the
    // settled switch has been seen low, so a switch left high through reset cannot start a game.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            start_meta_q  <= 1'b0;
            start_sync_q  <= 1'b0;
            start_prev_q  <= 1'b0;
            sync_v1_q     <= 1'b0;
            sync_v2_q     <= 1'b0;
            start_armed_q <= 1'b0;
            start_rise_q  <= 1'b0;
            start_fall_q  <= 1'b0;
        end else begin
            start_meta_q  <= start;
            start_sync_q  <= start_meta_q;
            start_prev_q  <= start_sync_q;
            sync_v1_q     <= 1'b1;
            sync_v2_q     <= sync_v1_q;
            start_armed_q <= start_armed_q | (sync_v2_q & ~start_sync_q);
            start_rise_q  <= start_sync_q & ~start_prev_q & start_armed_q;
            start_fall_q  <= ~start_sync_q & start_prev_q;
        end
    end

    // Free-running prescaler; tick is high for the one cycle in which the count sits at zero.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_q + TICK_BITS'(1);
            tick_q  <= (presc_q == PRESC_MAX);
        end
    end

    // Game state, scores, survival counter and sticky collision flag.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q      <= QI;
            p1_q         <= 4'd0;
            p2_q         <= 4'd0;
            winner_q     <= 2'b00;
            survive_q    <= 8'd0;
            hit_sticky_q <= 1'b0;
            respawn_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            winner_q     <= winner_d;
            survive_q    <= survive_d;
            hit_sticky_q <= hit_sticky_d;
            respawn_q    <= respawn_d;
        end
    end

    // Next-state logic: start/abort handling, per-tick collision and scoring decisions.
    always_comb begin
        state_d        = state_q;
        p1_d           = p1_q;
        p2_d           = p2_q;
        winner_d       = winner_q;
        survive_d      = survive_q;
        hit_sticky_d   = hit_sticky_q;
        respawn_d      = 1'b0;
        survive_inc_s  = survive_q + 8'd1;
        collide_s      = hit | hit_sticky_q;
        if (state_q == QGAME_2) begin
            active_score_s = p2_q;
        end else begin
            active_score_s = p1_q;
        end
        next_score_s   = score_inc(active_score_s);

        case (state_q)
            QI: begin
                hit_sticky_d = 1'b0;
                if (start_rise_q) begin
                    state_d   = QGAME_1;
                    p1_d      = 4'd0;
                    p2_d      = 4'd0;
                    winner_d  = 2'b00;
                    survive_d = 8'd0;
                    respawn_d = 1'b1;
                end else begin
                    state_d = QI;
                end
            end
            QGAME_1, QGAME_2: begin
                if (start_fall_q) begin
                    // Abort: scores stay on display, no winner declared.
                    state_d      = QI;
                    winner_d     = 2'b00;
                    survive_d    = 8'd0;
                    hit_sticky_d = 1'b0;
                end else if (tick_q) begin
                    hit_sticky_d = 1'b0;
                    if (collide_s) begin
                        // Collision beats a point earned on the same tick.
                        survive_d = 8'd0;
                        respawn_d = 1'b1;
                        state_d   = (state_q == QGAME_1) ? QGAME_2 : QGAME_1;
                    end else if (survive_inc_s >= SURV_L) begin
                        survive_d = 8'd0;
                        if (state_q == QGAME_1) begin
                            p1_d = next_score_s;
                        end else begin
                            p2_d = next_score_s;
                        end
                        if (next_score_s == WIN_L) begin
                            state_d  = QDONE;
                            winner_d = (state_q == QGAME_1) ? 2'b01 : 2'b10;
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        survive_d = survive_inc_s;
                    end
                end else begin
                    if (hit) begin
                        hit_sticky_d = 1'b1;
                    end else begin
                        hit_sticky_d = hit_sticky_q;
                    end
                end
            end
            QDONE: begin
                hit_sticky_d = 1'b0;
                if (start_fall_q) begin
                    state_d = QI;
                end else begin
                    state_d = QDONE;
                end
            end
            default: begin
                state_d = QI;
            end
        endcase
    end

    assign state    = state_q;
    assign p1_score = p1_q;
    assign p2_score = p2_q;
    assign winner   = winner_q;
    assign respawn  = respawn_q;
    assign tick     = tick_q;

endmodule
